// File: rtl/ddr4_req_arbiter_if.sv
// rtl/ddr4_req_arbiter_if.sv - requester, response, controller and refresh signals of the DDR4 request arbiter
interface ddr4_req_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 16
);
    localparam int ID_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_we;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic [NUM_REQ*DATA_W-1:0] req_wdata;
    logic [NUM_REQ*2-1:0]      req_bg_en;
    logic [NUM_REQ-1:0]        req_ack;
    logic [NUM_REQ-1:0]        req_err;
    logic [DATA_W-1:0]         rsp_rdata;
    logic                      rsp_valid;
    logic [ID_W-1:0]           rsp_id;
    logic [ADDR_W-1:0]         ctrl_addr;
    logic [DATA_W-1:0]         ctrl_wdata;
    logic [1:0]                ctrl_bg_en;
    logic                      ctrl_write_en;
    logic                      ctrl_read_en;
    logic                      ctrl_ready;
    logic [DATA_W-1:0]         ctrl_rdata;
    logic                      ref_req;
    logic                      ref_ack;
    logic                      ref_overrun;

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_bg_en,
        input  ctrl_ready, ctrl_rdata, ref_ack,
        output req_ack, req_err, rsp_rdata, rsp_valid, rsp_id,
        output ctrl_addr, ctrl_wdata, ctrl_bg_en, ctrl_write_en, ctrl_read_en,
        output ref_req, ref_overrun
    );

    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_bg_en,
        output ctrl_ready, ctrl_rdata, ref_ack,
        input  req_ack, req_err, rsp_rdata, rsp_valid, rsp_id,
        input  ctrl_addr, ctrl_wdata, ctrl_bg_en, ctrl_write_en, ctrl_read_en,
        input  ref_req, ref_overrun
    );
endinterface

// File: rtl/ddr4_req_arbiter.sv
// rtl/ddr4_req_arbiter.sv - round-robin arbiter sharing one DDR4 controller command port, with refresh windows
module ddr4_req_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 16,
    parameter int REFI    = 780,
    parameter int TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              rst,
    ddr4_req_arbiter_if.slave bus
);
    localparam int ID_W = $clog2(NUM_REQ);
    localparam int TO_W = $clog2(TIMEOUT + 1);
    localparam int RC_W = $clog2(REFI + 1);

    typedef enum logic [1:0] {IDLE, BUSY, REF, GAP} state_t;

    state_t              state, state_n;
    logic [ID_W-1:0]     rr_ptr, cur_id, grant_id;
    logic                cur_we;
    logic [ADDR_W-1:0]   cur_addr;
    logic [DATA_W-1:0]   cur_wdata;
    logic [1:0]          cur_bg;
    logic [TO_W-1:0]     busy_cnt;
    logic [RC_W-1:0]     ref_cnt;
    logic                ref_pending, ref_overrun_q, ref_expire, ref_done;
    logic                grant_found, grant_take;
    int                  scan_idx;
    logic [NUM_REQ-1:0]  ack_q, ack_n, err_q, err_n;
    logic                rsp_valid_q, rsp_valid_n;
    logic [DATA_W-1:0]   rsp_rdata_q;

    assign ref_expire = (ref_cnt == '0);
    assign ref_done   = (state == REF) && bus.ref_ack;

    // Round-robin winner: first valid requester after the last one granted.
    always_comb begin
        grant_found = 1'b0;
        grant_id    = '0;
        scan_idx    = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            scan_idx = (int'(rr_ptr) + k) % NUM_REQ;
            if (!grant_found && bus.req_valid[scan_idx]) begin
                grant_found = 1'b1;
                grant_id    = ID_W'(scan_idx);
            end
        end
    end

    // Next state and next-cycle completion pulses.
    always_comb begin
        state_n     = state;
        grant_take  = 1'b0;
        ack_n       = '0;
        err_n       = '0;
        rsp_valid_n = 1'b0;
        case (state)
            IDLE: begin
                if (ref_pending) begin
                    state_n = REF;
                end else if (grant_found) begin
                    grant_take = 1'b1;
                    state_n    = BUSY;
                end
            end
            BUSY: begin
                if (bus.ctrl_ready) begin
                    ack_n       = NUM_REQ'(1) << cur_id;
                    rsp_valid_n = !cur_we;
                    state_n     = GAP;
                end else if (busy_cnt == TO_W'(TIMEOUT - 1)) begin
                    err_n   = NUM_REQ'(1) << cur_id;
                    state_n = GAP;
                end
            end
            REF: begin
                if (bus.ref_ack) begin
                    state_n = GAP;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // State register, latched transaction and registered response pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            rr_ptr      <= ID_W'(NUM_REQ - 1);
            cur_id      <= '0;
            cur_we      <= 1'b0;
            cur_addr    <= '0;
            cur_wdata   <= '0;
            cur_bg      <= '0;
            busy_cnt    <= '0;
            ack_q       <= '0;
            err_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            state       <= state_n;
            ack_q       <= ack_n;
            err_q       <= err_n;
            rsp_valid_q <= rsp_valid_n;
            if (rsp_valid_n) begin
                rsp_rdata_q <= bus.ctrl_rdata;
            end
            if (grant_take) begin
                rr_ptr    <= grant_id;
                cur_id    <= grant_id;
                cur_we    <= bus.req_we[grant_id];
                cur_addr  <= bus.req_addr[int'(grant_id) * ADDR_W +: ADDR_W];
                cur_wdata <= bus.req_wdata[int'(grant_id) * DATA_W +: DATA_W];
                cur_bg    <= bus.req_bg_en[int'(grant_id) * 2 +: 2];
                busy_cnt  <= '0;
            end else if (state == BUSY) begin
                busy_cnt <= busy_cnt + 1'b1;
            end
        end
    end

    // Free-running refresh interval counter; an expiry that lands on a pending refresh is an overrun.
    always_ff @(posedge clk) begin
        if (rst) begin
            ref_cnt       <= RC_W'(REFI - 1);
            ref_pending   <= 1'b0;
            ref_overrun_q <= 1'b0;
        end else begin
            ref_cnt       <= ref_expire ? RC_W'(REFI - 1) : ref_cnt - 1'b1;
            ref_overrun_q <= ref_expire && ref_pending && !ref_done;
            if (ref_expire) begin
                ref_pending <= 1'b1;
            end else if (ref_done) begin
                ref_pending <= 1'b0;
            end
        end
    end

    assign bus.ctrl_write_en = (state == BUSY) && cur_we;
    assign bus.ctrl_read_en  = (state == BUSY) && !cur_we;
    assign bus.ctrl_addr     = (state == BUSY) ? cur_addr  : '0;
    assign bus.ctrl_wdata    = (state == BUSY) ? cur_wdata : '0;
    assign bus.ctrl_bg_en    = (state == BUSY) ? cur_bg    : '0;
    assign bus.ref_req       = (state == REF);
    assign bus.ref_overrun   = ref_overrun_q;
    assign bus.req_ack       = ack_q;
    assign bus.req_err       = err_q;
    assign bus.rsp_valid     = rsp_valid_q;
    assign bus.rsp_rdata     = rsp_rdata_q;
    assign bus.rsp_id        = cur_id;
endmodule

// File: tb/tb_ddr4_req_arbiter.sv
// tb/tb_ddr4_req_arbiter.sv - directed self-checking bench for ddr4_req_arbiter
module tb_ddr4_req_arbiter;
    localparam int NR = 4;
    localparam int AW = 32;
    localparam int DW = 16;

    logic clk = 1'b0;
    logic rst;
    int   n_pass  = 0;
    int   n_total = 0;

    always #5 clk = ~clk;

    ddr4_req_arbiter_if #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW)) bus ();

    ddr4_req_arbiter #(
        .NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW), .REFI(20), .TIMEOUT(8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic we, input logic [31:0] a, input logic [15:0] d);
        bus.req_we[i]                = we;
        bus.req_addr[i*AW +: AW]     = a;
        bus.req_wdata[i*DW +: DW]    = d;
        bus.req_bg_en[i*2 +: 2]      = 2'(i);
    endtask

    task automatic do_reset();
        rst            = 1'b1;
        bus.req_valid  = '0;
        bus.req_we     = '0;
        bus.req_addr   = '0;
        bus.req_wdata  = '0;
        bus.req_bg_en  = '0;
        bus.ctrl_ready = 1'b0;
        bus.ctrl_rdata = '0;
        bus.ref_ack    = 1'b0;
        cyc();
        cyc();
        rst = 1'b0;
    endtask

    int          wen_cnt, ren_cnt, ack_cnt, ack_cyc, rv_cnt, n_acks, overlap;
    int          ref_first, resume_cyc, post_ack_id, run_len, err_cyc, ovr_cnt, ovr_first;
    logic        gap_en, rv, prev_en, pre_ref_en, en, err_ack_nz, wen11, ref80, ref82;
    logic [3:0]  ack_val, err_val, exp_oh;
    logic [1:0]  ack_id, err_id, id11;
    logic [31:0] seen_addr, addr11;
    logic [15:0] seen_wdata, rd;

    initial begin
        // Test 1: single write, ready on third BUSY cycle
        do_reset();
        chk("rst_wen",  64'(bus.ctrl_write_en), 64'd0);
        chk("rst_ren",  64'(bus.ctrl_read_en),  64'd0);
        chk("rst_ack",  64'(bus.req_ack),       64'd0);
        chk("rst_ref",  64'(bus.ref_req),       64'd0);
        chk("rst_addr", 64'(bus.ctrl_addr),     64'd0);
        set_req(0, 1'b1, 32'h04050600, 16'h1234);
        bus.req_valid = 4'b0001;
        wen_cnt = 0; ren_cnt = 0; ack_cnt = 0; ack_cyc = -1; gap_en = 1'b1;
        seen_addr = '0; seen_wdata = '0; ack_val = '0; ack_id = '0;
        for (int c = 1; c <= 8; c++) begin
            cyc();
            if (bus.ctrl_write_en) begin
                wen_cnt++;
                seen_addr  = bus.ctrl_addr;
                seen_wdata = bus.ctrl_wdata;
            end
            if (bus.ctrl_read_en) ren_cnt++;
            if (bus.req_ack != 0) begin
                ack_cnt++;
                ack_cyc = c;
                ack_val = bus.req_ack;
                ack_id  = bus.rsp_id;
                gap_en  = bus.ctrl_write_en;
                bus.req_valid = '0;
            end
            bus.ctrl_ready = (c == 3);
        end
        chk("t1_wen_cycles", 64'(wen_cnt), 64'd3);
        chk("t1_ren_cycles", 64'(ren_cnt), 64'd0);
        chk("t1_ack_count",  64'(ack_cnt), 64'd1);
        chk("t1_ack_cycle",  64'(ack_cyc), 64'd4);
        chk("t1_ack_onehot", 64'(ack_val), 64'h1);
        chk("t1_rsp_id",     64'(ack_id),  64'd0);
        chk("t1_addr",       64'(seen_addr),  64'h04050600);
        chk("t1_wdata",      64'(seen_wdata), 64'h1234);
        chk("t1_gap_en",     64'(gap_en),  64'd0);

        // Test 2: all four requesting, ready immediate -> 0,1,2,3,0
        do_reset();
        for (int i = 0; i < NR; i++) set_req(i, 1'b0, 32'h100 * i, 16'h0);
        bus.req_valid  = 4'b1111;
        bus.ctrl_ready = 1'b1;
        n_acks = 0; overlap = 0;
        for (int c = 1; c <= 15; c++) begin
            cyc();
            if (bus.ctrl_read_en && bus.ctrl_write_en) overlap++;
            if (bus.req_ack != 0) begin
                exp_oh = 4'b0001 << (n_acks % 4);
                chk($sformatf("t2_ack%0d", n_acks), 64'(bus.req_ack), 64'(exp_oh));
                chk($sformatf("t2_id%0d", n_acks),  64'(bus.rsp_id),  64'(n_acks % 4));
                n_acks++;
            end
        end
        chk("t2_ack_total", 64'(n_acks), 64'd5);
        chk("t2_both_en",   64'(overlap), 64'd0);

        // Test 3: read from requester 2 returning BEEF
        do_reset();
        set_req(2, 1'b0, 32'h00002200, 16'h0);
        bus.req_valid = 4'b0100;
        wen_cnt = 0; ren_cnt = 0; rv_cnt = 0; ack_cyc = -1; rv = 1'b0; rd = '0;
        for (int c = 1; c <= 6; c++) begin
            cyc();
            if (bus.ctrl_read_en)  ren_cnt++;
            if (bus.ctrl_write_en) wen_cnt++;
            if (bus.rsp_valid)     rv_cnt++;
            if (bus.req_ack != 0) begin
                ack_cyc = c;
                ack_val = bus.req_ack;
                ack_id  = bus.rsp_id;
                rv      = bus.rsp_valid;
                rd      = bus.rsp_rdata;
                bus.req_valid = '0;
            end
            bus.ctrl_ready = (c == 2);
            bus.ctrl_rdata = (c == 2) ? 16'hBEEF : 16'h0000;
        end
        chk("t3_ack_cycle", 64'(ack_cyc), 64'd3);
        chk("t3_ack_onehot",64'(ack_val), 64'h4);
        chk("t3_rsp_valid", 64'(rv),      64'd1);
        chk("t3_rdata",     64'(rd),      64'hBEEF);
        chk("t3_rsp_id",    64'(ack_id),  64'd2);
        chk("t3_ren_cycles",64'(ren_cnt), 64'd2);
        chk("t3_wen_cycles",64'(wen_cnt), 64'd0);
        chk("t3_rv_count",  64'(rv_cnt),  64'd1);

        // Test 4: continuous traffic with a refresh window (REFI=20)
        do_reset();
        for (int i = 0; i < NR; i++) set_req(i, 1'b1, 32'h1000 + i, 16'h0);
        bus.req_valid  = 4'b1111;
        bus.ctrl_ready = 1'b1;
        ref_first = -1; resume_cyc = -1; post_ack_id = -1; overlap = 0;
        prev_en = 1'b0; pre_ref_en = 1'b1;
        for (int c = 1; c <= 30; c++) begin
            cyc();
            en = bus.ctrl_write_en | bus.ctrl_read_en;
            if (bus.ref_req && en) overlap++;
            if (bus.ref_req && ref_first < 0) begin
                ref_first  = c;
                pre_ref_en = prev_en;
            end
            if (ref_first >= 0 && !bus.ref_req && en && resume_cyc < 0) resume_cyc = c;
            if (ref_first >= 0 && c > ref_first && bus.req_ack != 0 && post_ack_id < 0)
                post_ack_id = int'(bus.rsp_id);
            bus.ref_ack = (ref_first >= 0 && c == ref_first + 1);
            prev_en = en;
        end
        chk("t4_ref_first",   64'(ref_first),   64'd22);
        chk("t4_pre_ref_en",  64'(pre_ref_en),  64'd0);
        chk("t4_en_during_ref", 64'(overlap),   64'd0);
        chk("t4_resume_cycle",64'(resume_cyc),  64'd26);
        chk("t4_resume_id",   64'(post_ack_id), 64'd3);

        // Test 5: ctrl_ready stuck low -> timeout after 8 cycles, then next requester
        do_reset();
        set_req(0, 1'b1, 32'hA000_0000, 16'h1111);
        set_req(1, 1'b1, 32'hA000_0001, 16'h2222);
        bus.req_valid = 4'b0011;
        run_len = 0; err_cyc = -1; err_val = '0; err_id = '0; err_ack_nz = 1'b1;
        wen11 = 1'b0; addr11 = '0; id11 = '0;
        for (int c = 1; c <= 12; c++) begin
            cyc();
            if (bus.ctrl_write_en && err_cyc < 0) run_len++;
            if (bus.req_err != 0) begin
                err_cyc    = c;
                err_val    = bus.req_err;
                err_ack_nz = (bus.req_ack != 0);
                err_id     = bus.rsp_id;
                bus.req_valid[0] = 1'b0;
            end
            if (c == 11) begin
                wen11  = bus.ctrl_write_en;
                addr11 = bus.ctrl_addr;
                id11   = bus.rsp_id;
            end
        end
        chk("t5_en_len",   64'(run_len),    64'd8);
        chk("t5_err_cycle",64'(err_cyc),    64'd9);
        chk("t5_err_onehot",64'(err_val),   64'h1);
        chk("t5_err_no_ack",64'(err_ack_nz),64'd0);
        chk("t5_err_id",   64'(err_id),     64'd0);
        chk("t5_next_wen", 64'(wen11),      64'd1);
        chk("t5_next_addr",64'(addr11),     64'hA000_0001);
        chk("t5_next_id",  64'(id11),       64'd1);

        // Test 6a: refresh never acknowledged -> overrun per expiry; ack coinciding with expiry
        do_reset();
        ovr_cnt = 0; ovr_first = -1; ref_first = -1; ref80 = 1'b1; ref82 = 1'b0;
        for (int c = 1; c <= 85; c++) begin
            cyc();
            if (bus.ref_overrun) begin
                ovr_cnt++;
                if (ovr_first < 0) ovr_first = c;
            end
            if (bus.ref_req && ref_first < 0) ref_first = c;
            if (c == 80) ref80 = bus.ref_req;
            if (c == 82) ref82 = bus.ref_req;
            bus.ref_ack = (c == 79);
        end
        chk("t6_ref_first", 64'(ref_first), 64'd21);
        chk("t6_ovr_count", 64'(ovr_cnt),   64'd2);
        chk("t6_ovr_first", 64'(ovr_first), 64'd40);
        chk("t6_ref_gap",   64'(ref80),     64'd0);
        chk("t6_ref_again", 64'(ref82),     64'd1);

        // Test 6b: reset in the middle of a BUSY transaction
        do_reset();
        set_req(0, 1'b0, 32'hC000_0000, 16'h0);
        set_req(2, 1'b1, 32'hC000_0002, 16'h5555);
        bus.req_valid = 4'b0100;
        cyc();
        chk("t6_busy_wen", 64'(bus.ctrl_write_en), 64'd1);
        cyc();
        rst = 1'b1;
        bus.req_valid = 4'b0101;
        cyc();
        rst = 1'b0;
        bus.ctrl_ready = 1'b1;
        chk("t6_rst_en",   64'({bus.ctrl_write_en, bus.ctrl_read_en}), 64'd0);
        chk("t6_rst_pulses", 64'({bus.req_ack, bus.req_err, bus.rsp_valid, bus.ref_overrun}), 64'd0);
        chk("t6_rst_ref",  64'(bus.ref_req),   64'd0);
        chk("t6_rst_addr", 64'(bus.ctrl_addr), 64'd0);
        chk("t6_rst_id",   64'(bus.rsp_id),    64'd0);
        cyc();
        chk("t6_first_ren",  64'(bus.ctrl_read_en), 64'd1);
        chk("t6_first_addr", 64'(bus.ctrl_addr),    64'hC000_0000);
        chk("t6_first_id",   64'(bus.rsp_id),       64'd0);
        cyc();
        chk("t6_first_ack",  64'(bus.req_ack),      64'h1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
